// File: rtl/ctx_sequencer_if.sv
// rtl/ctx_sequencer_if.sv - regfile and DMEM port bundle driven by the context sequencer
interface ctx_sequencer_if #(
    parameter int RF_AW = 6
) ();
    logic [RF_AW-1:0] rf_raddr;
    logic [31:0]      rf_rdata;
    logic             rf_we;
    logic [RF_AW-1:0] rf_waddr;
    logic [31:0]      rf_wdata;
    logic [31:0]      dmem_addr;
    logic             dmem_we;
    logic [31:0]      dmem_wdata;
    logic [31:0]      dmem_rdata;

    // sequencer side
    modport master (
        output rf_raddr,
        input  rf_rdata,
        output rf_we,
        output rf_waddr,
        output rf_wdata,
        output dmem_addr,
        output dmem_we,
        output dmem_wdata,
        input  dmem_rdata
    );

    // regfile / memory side
    modport slave (
        input  rf_raddr,
        output rf_rdata,
        input  rf_we,
        input  rf_waddr,
        input  rf_wdata,
        input  dmem_addr,
        input  dmem_we,
        input  dmem_wdata,
        output dmem_rdata
    );
endinterface

// File: rtl/ctx_sequencer.sv
// rtl/ctx_sequencer.sv - multi-cycle register-context save/restore engine for CALL/RET
module ctx_sequencer #(
    parameter int          NREGS     = 64,
    parameter int          RF_AW     = 6,
    parameter logic [31:0] SP_INIT   = 32'h0000_FFFC,
    parameter int          MAX_DEPTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [1:0]            i_state_mode_next,
    output logic [1:0]            o_state_mode,
    output logic [7:0]            o_sc,
    output logic                  o_stall,
    ctx_sequencer_if.master       io_mem,
    output logic [31:0]           o_sp,
    output logic [3:0]            o_depth,
    output logic                  o_err
);
    // state encoding doubles as the state_mode value the decoder reads back
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALL = 2'd1,
        ST_RET  = 2'd2
    } state_t;

    localparam logic [7:0]  LP_LAST  = 8'(NREGS);
    localparam logic [31:0] LP_FRAME = 32'(4 * NREGS);
    localparam logic [3:0]  LP_MAX   = 4'(MAX_DEPTH);

    state_t      r_state, w_state_next;
    logic [7:0]  r_sc, w_sc_next;
    logic [31:0] r_sp, w_sp_next;
    logic [3:0]  r_depth, w_depth_next;
    logic        r_err, w_err_next;
    logic [31:0] w_sc_bytes;

    // step counter as a byte offset into the frame
    assign w_sc_bytes = {22'd0, r_sc, 2'b00};

    // state, counter, stack pointer and depth registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_sc    <= 8'd0;
            r_sp    <= SP_INIT;
            r_depth <= 4'd0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_sc    <= w_sc_next;
            r_sp    <= w_sp_next;
            r_depth <= w_depth_next;
            r_err   <= w_err_next;
        end
    end

    // next-state and per-step regfile/DMEM port drive
    always_comb begin
        w_state_next      = r_state;
        w_sc_next         = r_sc;
        w_sp_next         = r_sp;
        w_depth_next      = r_depth;
        w_err_next        = r_err;
        io_mem.rf_raddr   = '0;
        io_mem.rf_we      = 1'b0;
        io_mem.rf_waddr   = '0;
        io_mem.rf_wdata   = 32'd0;
        io_mem.dmem_addr  = 32'd0;
        io_mem.dmem_we    = 1'b0;
        io_mem.dmem_wdata = 32'd0;

        case (r_state)
            ST_IDLE: begin
                w_sc_next = 8'd0;
                case (i_state_mode_next)
                    2'd1: begin
                        if (r_depth == LP_MAX) w_err_next = 1'b1;
                        else                   w_state_next = ST_CALL;
                    end
                    2'd2: begin
                        if (r_depth == 4'd0) w_err_next = 1'b1;
                        else                 w_state_next = ST_RET;
                    end
                    default: ;
                endcase
            end
            ST_CALL: begin
                w_sc_next = r_sc + 8'd1;
                if (r_sc == LP_LAST) begin
                    w_state_next = ST_IDLE;
                    w_sc_next    = 8'd0;
                    w_sp_next    = r_sp - LP_FRAME;
                    w_depth_next = r_depth + 4'd1;
                end else begin
                    // frame base is where sp will point once the CALL completes
                    io_mem.rf_raddr   = RF_AW'(r_sc);
                    io_mem.dmem_we    = 1'b1;
                    io_mem.dmem_addr  = r_sp - LP_FRAME + w_sc_bytes;
                    io_mem.dmem_wdata = io_mem.rf_rdata;
                end
            end
            ST_RET: begin
                w_sc_next = r_sc + 8'd1;
                if (r_sc != LP_LAST) io_mem.dmem_addr = r_sp + w_sc_bytes;
                // DMEM read data lags its address by one cycle, so writes trail by one step
                if (r_sc != 8'd0) begin
                    io_mem.rf_we    = 1'b1;
                    io_mem.rf_waddr = RF_AW'(r_sc - 8'd1);
                    io_mem.rf_wdata = io_mem.dmem_rdata;
                end
                if (r_sc == LP_LAST) begin
                    w_state_next = ST_IDLE;
                    w_sc_next    = 8'd0;
                    w_sp_next    = r_sp + LP_FRAME;
                    w_depth_next = r_depth - 4'd1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_sc_next    = 8'd0;
            end
        endcase
    end

    assign o_state_mode = r_state;
    assign o_sc         = r_sc;
    assign o_stall      = (r_state != ST_IDLE);
    assign o_sp         = r_sp;
    assign o_depth      = r_depth;
    assign o_err        = r_err;
endmodule

// File: tb/tb_ctx_sequencer.sv
// tb/tb_ctx_sequencer.sv - scoreboard bench for ctx_sequencer with a frame-stack reference model
`timescale 1ns/1ps
module tb_ctx_sequencer;
    localparam int          NREGS     = 64;
    localparam int          RF_AW     = 6;
    localparam logic [31:0] SP_INIT   = 32'h0000_FFFC;
    localparam int          MAX_DEPTH = 8;
    localparam logic [31:0] FRAME     = 32'(4 * NREGS);

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [7:0]  sc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  smn = 2'd0;
    logic [1:0]  mode;
    logic [7:0]  sc;
    logic        stall;
    logic [31:0] sp;
    logic [3:0]  depth;
    logic        err;

    int n_checks = 0;
    int n_errors = 0;

    ctx_sequencer_if #(.RF_AW(RF_AW)) u_if ();

    ctx_sequencer #(
        .NREGS(NREGS), .RF_AW(RF_AW), .SP_INIT(SP_INIT), .MAX_DEPTH(MAX_DEPTH)
    ) u_dut (
        .i_clk(clk), .i_rst(rst), .i_state_mode_next(smn),
        .o_state_mode(mode), .o_sc(sc), .o_stall(stall),
        .io_mem(u_if), .o_sp(sp), .o_depth(depth), .o_err(err)
    );

    always #5 clk = ~clk;

    // regfile (combinational read) and DMEM (synchronous read)
    logic [31:0] rf      [NREGS];
    logic [31:0] rf_load [NREGS];
    logic        load_rf = 1'b0;
    logic [31:0] dmem    [16384];
    logic [31:0] dmem_q;

    assign u_if.rf_rdata   = rf[u_if.rf_raddr];
    assign u_if.dmem_rdata = dmem_q;

    always @(posedge clk) begin
        dmem_q <= dmem[u_if.dmem_addr[15:2]];
        if (u_if.dmem_we) dmem[u_if.dmem_addr[15:2]] <= u_if.dmem_wdata;
        if (load_rf) begin
            for (int k = 0; k < NREGS; k++) rf[k] <= rf_load[k];
        end else if (u_if.rf_we) begin
            rf[u_if.rf_waddr] <= u_if.rf_wdata;
        end
    end

    // reference model: register values and a stack of saved frames
    logic [31:0] m_rf [NREGS];
    logic [31:0] m_stack [$];
    int          m_depth = 0;
    bit          m_err   = 1'b0;
    exp_t        q_dm [$];
    exp_t        q_rf [$];

    function automatic logic [31:0] m_sp();
        return SP_INIT - 32'(m_depth) * FRAME;
    endfunction

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // monitor: every DUT memory write must match the next expected one
    always @(negedge clk) begin
        if (!rst) begin
            if (u_if.dmem_we) begin
                if (q_dm.size() == 0) begin
                    chk("dmem_unexpected_write", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = q_dm.pop_front();
                    chk("dmem_addr", u_if.dmem_addr, e.addr);
                    chk("dmem_wdata", u_if.dmem_wdata, e.data);
                    chk("dmem_sc", 32'(sc), 32'(e.sc));
                end
            end
            if (u_if.rf_we) begin
                if (q_rf.size() == 0) begin
                    chk("rf_unexpected_write", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = q_rf.pop_front();
                    chk("rf_waddr", 32'(u_if.rf_waddr), e.addr);
                    chk("rf_wdata", u_if.rf_wdata, e.data);
                    chk("rf_sc", 32'(sc), 32'(e.sc));
                end
            end
        end
    end

    task automatic model_reset();
        m_depth = 0;
        m_err   = 1'b0;
        m_stack.delete();
        q_dm.delete();
        q_rf.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        smn = 2'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mode", 32'(mode), 32'd0);
        chk("rst_sc", 32'(sc), 32'd0);
        chk("rst_sp", sp, SP_INIT);
        chk("rst_depth", 32'(depth), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_we", 32'({u_if.rf_we, u_if.dmem_we}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic set_rf(input bit incr);
        for (int k = 0; k < NREGS; k++) begin
            rf_load[k] = incr ? 32'(k + 100) : $urandom;
            m_rf[k]    = rf_load[k];
        end
        @(negedge clk);
        load_rf = 1'b1;
        @(negedge clk);
        load_rf = 1'b0;
    endtask

    task automatic start_op(input logic [1:0] cmd, output bit acc);
        acc = 1'b0;
        if (cmd == 2'd1) begin
            if (m_depth == MAX_DEPTH) m_err = 1'b1;
            else begin
                acc = 1'b1;
                for (int k = 0; k < NREGS; k++) begin
                    q_dm.push_back('{addr: m_sp() - FRAME + 32'(4 * k), data: m_rf[k], sc: 8'(k)});
                    m_stack.push_back(m_rf[k]);
                end
                m_depth++;
            end
        end else if (cmd == 2'd2) begin
            if (m_depth == 0) m_err = 1'b1;
            else begin
                int base;
                acc  = 1'b1;
                base = m_stack.size() - NREGS;
                for (int k = 0; k < NREGS; k++) begin
                    q_rf.push_back('{addr: 32'(k), data: m_stack[base + k], sc: 8'(k + 1)});
                    m_rf[k] = m_stack[base + k];
                end
                repeat (NREGS) void'(m_stack.pop_back());
                m_depth--;
            end
        end
        @(negedge clk);
        smn = cmd;
        @(negedge clk);
        smn = 2'd0;
        chk("mode_after_req", 32'(mode), acc ? 32'(cmd) : 32'd0);
        chk("stall_after_req", 32'(stall), 32'(acc));
    endtask

    task automatic finish_op(input bit noise);
        int cyc = 0;
        while (mode != 2'd0 && cyc < 300) begin
            if (noise) smn = (sc == 8'd10) ? 2'd2 : 2'($urandom_range(0, 3));
            @(negedge clk);
            cyc++;
        end
        smn = 2'd0;
        chk("op_len", 32'(cyc), 32'(NREGS + 1));
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_mode"}, 32'(mode), 32'd0);
        chk({tag, "_stall"}, 32'(stall), 32'd0);
        chk({tag, "_sp"}, sp, m_sp());
        chk({tag, "_depth"}, 32'(depth), 32'(m_depth));
        chk({tag, "_err"}, 32'(err), 32'(m_err));
        chk({tag, "_pending"}, 32'(q_dm.size() + q_rf.size()), 32'd0);
    endtask

    task automatic run_op(input logic [1:0] cmd, input bit noise, input string tag);
        bit acc;
        start_op(cmd, acc);
        if (acc) finish_op(noise);
        check_idle(tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        int cyc;
        int bad;
        for (int k = 0; k < NREGS; k++) m_rf[k] = 32'd0;

        // save then restore one frame
        do_reset();
        set_rf(1'b1);
        run_op(2'd1, 1'b0, "call1");
        chk("call1_sp_abs", sp, 32'h0000_FEFC);
        bad = 0;
        for (int k = 0; k < NREGS; k++)
            if (dmem[(32'h0000_FEFC + 32'(4 * k)) >> 2] !== 32'(k + 100)) bad++;
        chk("call1_frame_contents", 32'(bad), 32'd0);
        set_rf(1'b0);
        run_op(2'd2, 1'b0, "ret1");
        chk("ret1_sp_abs", sp, SP_INIT);
        bad = 0;
        for (int k = 0; k < NREGS; k++) if (rf[k] !== 32'(k + 100)) bad++;
        chk("ret1_regs_restored", 32'(bad), 32'd0);

        // underflow
        run_op(2'd2, 1'b0, "ret_underflow");
        chk("ret_underflow_err_abs", 32'(err), 32'd1);

        // overflow on the ninth nested CALL
        do_reset();
        for (int i = 0; i < MAX_DEPTH + 1; i++) begin
            set_rf(1'b0);
            run_op(2'd1, 1'b0, "nest");
        end
        chk("nest_depth_abs", 32'(depth), 32'd8);
        chk("nest_sp_abs", sp, SP_INIT - 32'd2048);
        for (int i = 0; i < MAX_DEPTH; i++) run_op(2'd2, 1'b0, "unnest");

        // reset in the middle of a CALL
        do_reset();
        set_rf(1'b0);
        start_op(2'd1, acc);
        cyc = 0;
        while (sc != 8'd30 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("midrst_reach_sc30", 32'(sc), 32'd30);
        #2;
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        chk("midrst_mode", 32'(mode), 32'd0);
        chk("midrst_sc", 32'(sc), 32'd0);
        chk("midrst_sp", sp, SP_INIT);
        chk("midrst_depth", 32'(depth), 32'd0);
        chk("midrst_dmem_we", 32'(u_if.dmem_we), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op(2'd1, 1'b0, "after_midrst");

        // mode requests during a busy CALL are ignored
        set_rf(1'b0);
        run_op(2'd1, 1'b1, "noise_call");
        run_op(2'd3, 1'b0, "reserved");

        // randomized CALL/RET mix
        for (int i = 0; i < 30; i++) begin
            int r;
            logic [1:0] cmd;
            r   = $urandom_range(0, 9);
            cmd = (r < 5) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
            if ($urandom_range(0, 1) == 1) set_rf(1'b0);
            run_op(cmd, 1'($urandom_range(0, 1)), "rand");
        end
        bad = 0;
        for (int k = 0; k < NREGS; k++) if (rf[k] !== m_rf[k]) bad++;
        chk("rand_final_regs", 32'(bad), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
